rr_arbiter: RTL and testbench
=============================

// Module: rr_arbiter
// PURPOSE
//  Registered round-robin arbiter sharing one downstream resource among W
//  requesters. Fairness pointer = last acknowledged grant (one-hot).
//  Priority masking done by the existing mask block.
//  Grant is held until the downstream accepts it (i_ack).
//  Sits in front of any shared port/bus; one instance per shared resource.
// PARAMETERS
//  W       4   number of requesters (>= 1)
//  IDX_W   (W>1)?$clog2(W):1   width of encoded grant index (derived, localparam)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  arst_n     in   1      asynchronous reset, active-low
//  i_req      in   W      per-requester request, level
//  i_ack      in   1      downstream accepts current grant this cycle
//  o_gnt      out  W      one-hot grant (all-zero when idle)
//  o_gnt_vld  out  1      grant valid (== |o_gnt)
//  o_gnt_idx  out  IDX_W  binary index of o_gnt; 0 when idle
// BEHAVIOUR
//  - Reset (arst_n=0, async): o_gnt=0, o_gnt_vld=0, o_gnt_idx=0, state=IDLE,
//    ptr=1<<(W-1) (so requester 0 has top priority after reset).
//  - All outputs registered; no combinational path from i_req/i_ack to outputs.
//  - pick(req,ptr): above = mask(ptr, TOWARDS_LSB=0, INCLUSIVE=0) (bits strictly
//    above ptr); m = req & above; if |m -> lowest set bit of m,
//    else lowest set bit of req; 0 if req==0.
//  - FSM (2 states):
//    IDLE: if |i_req -> o_gnt <= pick(i_req,ptr), -> BUSY. Latency: req seen
//          in cycle N -> o_gnt_vld=1 in cycle N+1. Else stay IDLE.
//    BUSY: o_gnt/o_gnt_idx held stable while !i_ack, regardless of i_req changes
//          (no pre-emption, no withdrawal).
//          On i_ack: ptr <= o_gnt; nxt = pick(i_req, o_gnt) (i_req sampled this
//          cycle, current grantee eligible at lowest priority);
//          if |nxt -> o_gnt <= nxt, stay BUSY (back-to-back, no bubble);
//          else o_gnt <= 0, -> IDLE.
//  - i_ack in IDLE: ignored, no state change.
//  - Requester withdrawing i_req while granted: protocol violation; grant still
//    held until i_ack.
//  - Wrap-around: ptr at MSB -> mask empty -> lowest requester wins.
//  - W=1: grant=i_req[0] path; o_gnt_idx constant 0.
//  - Reset mid-BUSY: outputs clear immediately (async); pointer returns to MSB.
//  - Assertions: $onehot0(o_gnt); o_gnt_vld==|o_gnt; o_gnt stable while
//    o_gnt_vld && !i_ack; !(i_ack && !o_gnt_vld) flagged as warning;
//    o_gnt_vld && !i_req[o_gnt_idx] flagged as error (withdrawal).
// STRUCTURE
//  - Package rr_arbiter_pkg: state_t enum {IDLE, BUSY}.
//  - Sub-module: mask (existing) for priority mask; find-first-set and
//    one-hot->binary encode inline as functions.
//  - Registers: state, ptr[W], gnt[W], gnt_idx[IDX_W].
// TESTING
//  1 Reset: hold arst_n=0 -> o_gnt=0, o_gnt_vld=0, o_gnt_idx=0; release,
//    i_req=0 -> stays idle.
//  2 W=4, i_req=4'b1111 constant, i_ack=1 every BUSY cycle -> o_gnt sequence
//    0001,0010,0100,1000,0001, no idle cycles between.
//  3 Wrap: grant 0100 acked with i_req=4'b0001 -> next o_gnt=0001, idx=0.
//  4 Hold: i_req=0011 -> o_gnt=0001; keep i_ack=0 10 cycles -> o_gnt stays
//    0001; then i_ack=1 -> o_gnt=0010 next cycle.
//  5 Single requester: i_req=0100 only, i_ack pulses each cycle -> o_gnt=0100
//    every cycle, o_gnt_vld never drops; drop req with ack -> IDLE next cycle.
//  6 Reset mid-BUSY: o_gnt=0010, assert arst_n=0 -> outputs 0 in same cycle;
//    release, i_req=1010 -> o_gnt=0010 (ptr reset to MSB).

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// Shared types for the round-robin arbiter.
// No logic, no latency.
// No flow control.
package rr_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/rr_arbiter_mask.sv
// Priority mask: marks every bit above (or below) the set bit of a one-hot vector.
// Combinational, zero latency.
// No flow control.
module rr_arbiter_mask #(
   parameter int W           = 4,
   parameter bit TOWARDS_LSB = 1'b0,
   parameter bit INCLUSIVE   = 1'b0
) (
   input  logic [W-1:0] vec,
   output logic [W-1:0] msk
);

   // running OR of the pointer, swept away from the pointer bit
   always_comb begin
      logic acc;
      acc = 1'b0;
      msk = '0;
      if (!TOWARDS_LSB) begin
         for (int i = 0; i < W; i++) begin
            if (INCLUSIVE) acc = acc | vec[i];
            msk[i] = acc;
            if (!INCLUSIVE) acc = acc | vec[i];
         end
      end else begin
         for (int i = W - 1; i >= 0; i--) begin
            if (INCLUSIVE) acc = acc | vec[i];
            msk[i] = acc;
            if (!INCLUSIVE) acc = acc | vec[i];
         end
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter; one-hot grant held until the downstream acks it.
// Request seen in cycle N gives a valid grant in cycle N+1; ack-to-next-grant has no bubble.
// A grant is never withdrawn or pre-empted: it stays stable until i_ack.
module rr_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter  int W     = 4,
   localparam int IDX_W = (W > 1) ? $clog2(W) : 1
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic [W-1:0]     i_req,
   input  logic             i_ack,
   output logic [W-1:0]     o_gnt,
   output logic             o_gnt_vld,
   output logic [IDX_W-1:0] o_gnt_idx
);

   state_t           state_q, state_d;
   logic [W-1:0]     ptr_q, ptr_d;
   logic [W-1:0]     gnt_q, gnt_d;
   logic [IDX_W-1:0] idx_q;
   logic             vld_q;

   logic [W-1:0]     ptr_sel;
   logic [W-1:0]     above;
   logic [W-1:0]     nxt;

   // isolate the lowest set bit
   function automatic logic [W-1:0] lowest_bit(input logic [W-1:0] v);
      lowest_bit = v & (~v + W'(1));
   endfunction

   // one-hot to binary
   function automatic logic [IDX_W-1:0] encode(input logic [W-1:0] v);
      encode = '0;
      for (int i = 0; i < W; i++) begin
         if (v[i]) encode = encode | IDX_W'(i);
      end
   endfunction

   // While busy the current grantee acts as the pointer, so it ends up lowest priority
   assign ptr_sel = (state_q == BUSY) ? gnt_q : ptr_q;

   rr_arbiter_mask #(
      .W           (W),
      .TOWARDS_LSB (1'b0),
      .INCLUSIVE   (1'b0)
   ) u_mask (
      .vec (ptr_sel),
      .msk (above)
   );

   // first requester above the pointer, else wrap to the lowest requester
   assign nxt = (|(i_req & above)) ? lowest_bit(i_req & above) : lowest_bit(i_req);

   // next-state and next-grant decision
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      case (state_q)
         IDLE: begin
            if (|i_req) begin
               gnt_d   = nxt;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (i_ack) begin
               ptr_d = gnt_q;
               if (|nxt) begin
                  gnt_d = nxt;
               end else begin
                  gnt_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // state and registered outputs; pointer parks at the MSB so requester 0 wins first
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= IDLE;
         ptr_q   <= {1'b1, {(W-1){1'b0}}};
         gnt_q   <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         idx_q   <= encode(gnt_d);
         vld_q   <= |gnt_d;
      end
   end

   assign o_gnt     = gnt_q;
   assign o_gnt_vld = vld_q;
   assign o_gnt_idx = idx_q;

`ifndef SYNTHESIS
   a_onehot : assert property (@(posedge clk) disable iff (!arst_n) $onehot0(o_gnt));
   a_vld    : assert property (@(posedge clk) disable iff (!arst_n) o_gnt_vld == (|o_gnt));
   a_stable : assert property (@(posedge clk) disable iff (!arst_n)
                               (o_gnt_vld && !i_ack) |=> $stable(o_gnt));
   a_idleack: assert property (@(posedge clk) disable iff (!arst_n) !(i_ack && !o_gnt_vld))
      else $warning("ack while no grant outstanding");
   // dropping the request in the ack cycle itself is a clean hand-off
   a_withdraw: assert property (@(posedge clk) disable iff (!arst_n)
                               (o_gnt_vld && !i_ack) |-> i_req[o_gnt_idx])
      else $error("granted requester withdrew its request");
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
module tb_rr_arbiter;

   localparam int W     = 4;
   localparam int IDX_W = 2;

   logic             clk = 1'b0;
   logic             arst_n;
   logic [W-1:0]     i_req;
   logic             i_ack;
   logic [W-1:0]     o_gnt;
   logic             o_gnt_vld;
   logic [IDX_W-1:0] o_gnt_idx;

   typedef struct {
      logic [W-1:0]     gnt;
      logic             vld;
      logic [IDX_W-1:0] idx;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // reference model: who holds the grant, and who was last acknowledged
   bit   m_busy;
   int   m_idx;
   int   m_last;

   always #5 clk = ~clk;

   rr_arbiter #(.W(W)) dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .i_req     (i_req),
      .i_ack     (i_ack),
      .o_gnt     (o_gnt),
      .o_gnt_vld (o_gnt_vld),
      .o_gnt_idx (o_gnt_idx)
   );

   // circular search starting just after the last acknowledged requester
   function automatic int rr_pick(logic [W-1:0] req, int last);
      int j;
      for (int k = 1; k <= W; k++) begin
         j = (last + k) % W;
         if (req[j]) return j;
      end
      return -1;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_idx  = 0;
      m_last = W - 1;
      sb_q.delete();
   endtask

   // apply one cycle of stimulus and queue what the outputs must be after the edge
   task automatic drive(logic [W-1:0] req, logic ack);
      exp_t e;
      @(negedge clk);
      i_req = req;
      i_ack = ack;
      if (!m_busy) begin
         if (req != 0) begin
            m_idx  = rr_pick(req, m_last);
            m_busy = 1'b1;
         end
      end else if (ack) begin
         m_last = m_idx;
         if (req != 0) m_idx = rr_pick(req, m_last);
         else          m_busy = 1'b0;
      end
      e.gnt = '0;
      if (m_busy) e.gnt[m_idx] = 1'b1;
      e.vld = m_busy;
      e.idx = m_busy ? IDX_W'(m_idx) : '0;
      sb_q.push_back(e);
   endtask

   task automatic check_zero(string tag);
      check({tag, "_gnt"}, 32'(o_gnt), 32'd0);
      check({tag, "_vld"}, 32'(o_gnt_vld), 32'd0);
      check({tag, "_idx"}, 32'(o_gnt_idx), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      arst_n = 1'b0;
      i_req  = '0;
      i_ack  = 1'b0;
      model_reset();
      #1;
      check_zero("rst");
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
   endtask

   // monitor: compare DUT outputs against the scoreboard each cycle
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("gnt", 32'(o_gnt), 32'(e.gnt));
            check("vld", 32'(o_gnt_vld), 32'(e.vld));
            check("idx", 32'(o_gnt_idx), 32'(e.idx));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] r;
      logic         a;
      arst_n = 1'b0;
      i_req  = '0;
      i_ack  = 1'b0;
      model_reset();

      // reset, then idle with no requests
      do_reset();
      drive(4'b0000, 1'b0);
      drive(4'b0000, 1'b0);

      // full rotation with constant requests and back-to-back acks
      drive(4'b1111, 1'b0);
      repeat (4) drive(4'b1111, 1'b1);

      // wrap: grant 0100 acked while only requester 0 asks
      drive(4'b1111, 1'b1);
      drive(4'b1111, 1'b1);
      drive(4'b0001, 1'b1);
      drive(4'b0000, 1'b1);

      // hold without ack for 10 cycles
      do_reset();
      drive(4'b0011, 1'b0);
      repeat (10) drive(4'b0011, 1'b0);
      drive(4'b0011, 1'b1);
      drive(4'b0000, 1'b1);

      // single requester re-granted every cycle, then released
      do_reset();
      drive(4'b0100, 1'b0);
      repeat (5) drive(4'b0100, 1'b1);
      drive(4'b0000, 1'b1);
      drive(4'b0000, 1'b0);

      // reset in the middle of a held grant
      do_reset();
      drive(4'b0010, 1'b0);
      drive(4'b0010, 1'b0);
      @(posedge clk);
      #3;
      arst_n = 1'b0;
      #1;
      check_zero("midrst");
      model_reset();
      i_req = '0;
      @(negedge clk);
      @(negedge clk);
      arst_n = 1'b1;
      drive(4'b1010, 1'b0);
      drive(4'b1010, 1'b1);
      drive(4'b0000, 1'b1);

      // randomized traffic; the current grantee keeps requesting until acked
      do_reset();
      for (int n = 0; n < 600; n++) begin
         r = W'($urandom);
         if ($urandom_range(0, 3) == 0) r = r & W'(1 << $urandom_range(0, W - 1));
         if (m_busy) begin
            a = 1'($urandom_range(0, 1));
            if (!a) r[m_idx] = 1'b1;
         end else begin
            a = 1'b0;
            if ($urandom_range(0, 4) == 0) r = '0;
         end
         drive(r, a);
      end

      @(posedge clk);
      #2;
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
